// File: rtl/v_loadunit_if.sv
// Vector load unit bus: sequencer request/handshake, bank
// address/data lanes and the packed writeback image.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 14
`endif

interface v_loadunit_if #(
    parameter int ADDR_W = `DATAMEM_BITS
) ();
    logic              start;
    logic [3:0]        load_op;
    logic [2:0]        lmul;
    logic [4:0]        stride;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in0;
    logic [31:0]       data_in1;
    logic [31:0]       data_in2;
    logic [31:0]       data_in3;
    logic              rd_en;
    logic [ADDR_W-1:0] data_addr0;
    logic [ADDR_W-1:0] data_addr1;
    logic [ADDR_W-1:0] data_addr2;
    logic [ADDR_W-1:0] data_addr3;
    logic              busy;
    logic [511:0]      l_data_out;
    logic              done;

    modport master (
        output start, load_op, lmul, stride, address,
        output data_in0, data_in1, data_in2, data_in3,
        input  rd_en, data_addr0, data_addr1, data_addr2, data_addr3,
        input  busy, l_data_out, done
    );

    modport slave (
        input  start, load_op, lmul, stride, address,
        input  data_in0, data_in1, data_in2, data_in3,
        output rd_en, data_addr0, data_addr1, data_addr2, data_addr3,
        output busy, l_data_out, done
    );
endinterface

// File: rtl/v_loadunit.sv
// Vector load data unit: issues four-bank word reads per beat and packs
// 8/16/32-bit elements into a 512-bit register-group image.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 14
`endif

package v_pkg;
    localparam logic [3:0] VLSU_NOP    = 4'd0;
    localparam logic [3:0] VLSU_VLE8   = 4'd1;
    localparam logic [3:0] VLSU_VLE16  = 4'd2;
    localparam logic [3:0] VLSU_VLE32  = 4'd3;
    localparam logic [3:0] VLSU_VLSE8  = 4'd4;
    localparam logic [3:0] VLSU_VLSE16 = 4'd5;
    localparam logic [3:0] VLSU_VLSE32 = 4'd6;
    localparam logic [3:0] VLSU_VSE8   = 4'd7;
    localparam logic [3:0] VLSU_VSE16  = 4'd8;
    localparam logic [3:0] VLSU_VSE32  = 4'd9;
    localparam logic [3:0] VLSU_VSSE8  = 4'd10;
    localparam logic [3:0] VLSU_VSSE16 = 4'd11;
    localparam logic [3:0] VLSU_VSSE32 = 4'd12;
endpackage

module v_loadunit
    import v_pkg::*;
#(
    parameter int VLEN   = 128,
    parameter int ADDR_W = `DATAMEM_BITS
) (
    input  logic        clk,
    input  logic        nrst,
    v_loadunit_if.slave bus
);
    // e8 beats per register; wider elements halve it
    localparam int BPR = VLEN / 32;
    localparam int NB  = $clog2(BPR * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NB-1:0]     b_q, b_d;
    logic [NB-1:0]     last_q;
    logic [NB-1:0]     cb_q;
    logic              cap_q;
    logic [1:0]        ew_q;
    logic              strd_q;
    logic [4:0]        stride_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q [4];
    logic [ADDR_W-1:0] addr_d [4];
    logic [511:0]      ldata_q, ldata_d;

    logic              is_load;
    logic [1:0]        ew_dec;
    logic              strd_dec;
    logic [1:0]        lmul_sh;
    logic [NB:0]       n_dec;
    logic              accept;

    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] base,
        input logic [4:0]        st,
        input logic              strided,
        input logic [NB-1:0]     b,
        input logic [1:0]        k
    );
        logic [ADDR_W-1:0] e;
        logic [ADDR_W-1:0] s;
        e = ADDR_W'({b, k});
        s = strided ? ADDR_W'(st) : ADDR_W'(1);
        return base + s * e;
    endfunction

    always_comb begin
        is_load  = 1'b1;
        ew_dec   = 2'd0;
        strd_dec = 1'b0;
        case (bus.load_op)
            VLSU_VLE8:   ew_dec = 2'd0;
            VLSU_VLE16:  ew_dec = 2'd1;
            VLSU_VLE32:  ew_dec = 2'd2;
            VLSU_VLSE8: begin
                ew_dec   = 2'd0;
                strd_dec = 1'b1;
            end
            VLSU_VLSE16: begin
                ew_dec   = 2'd1;
                strd_dec = 1'b1;
            end
            VLSU_VLSE32: begin
                ew_dec   = 2'd2;
                strd_dec = 1'b1;
            end
            default:     is_load = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.lmul)
            3'b001:  lmul_sh = 2'd1;
            3'b010:  lmul_sh = 2'd2;
            default: lmul_sh = 2'd0;
        endcase
        n_dec = ((NB+1)'(BPR) >> ew_dec) << lmul_sh;
    end

    assign accept = (state_q == S_IDLE) && bus.start && is_load;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    b_d     = '0;
                    for (int k = 0; k < 4; k++) begin
                        addr_d[k] = elem_addr(bus.address, bus.stride,
                                              strd_dec, '0, 2'(k));
                    end
                end
            end
            S_ISSUE: begin
                if (b_q == last_q) begin
                    state_d = S_DRAIN;
                end else begin
                    b_d = b_q + 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        addr_d[k] = elem_addr(base_q, stride_q,
                                              strd_q, b_d, 2'(k));
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // cap_q/cb_q trail the issue beat by one cycle to match bank latency
    always_comb begin
        ldata_d = ldata_q;
        if (accept) begin
            ldata_d = '0;
        end else if (cap_q) begin
            case (ew_q)
                2'd0: ldata_d[32*int'(cb_q) +: 32] = {
                    bus.data_in3[7:0], bus.data_in2[7:0],
                    bus.data_in1[7:0], bus.data_in0[7:0]};
                2'd1: ldata_d[64*int'(cb_q) +: 64] = {
                    bus.data_in3[15:0], bus.data_in2[15:0],
                    bus.data_in1[15:0], bus.data_in0[15:0]};
                default: ldata_d[128*int'(cb_q) +: 128] = {
                    bus.data_in3, bus.data_in2,
                    bus.data_in1, bus.data_in0};
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            b_q      <= '0;
            last_q   <= '0;
            cb_q     <= '0;
            cap_q    <= 1'b0;
            ew_q     <= 2'd0;
            strd_q   <= 1'b0;
            stride_q <= '0;
            base_q   <= '0;
            addr_q   <= '{default: '0};
            ldata_q  <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            cap_q   <= (state_q == S_ISSUE);
            cb_q    <= b_q;
            ldata_q <= ldata_d;
            if (accept) begin
                ew_q     <= ew_dec;
                strd_q   <= strd_dec;
                stride_q <= bus.stride;
                base_q   <= bus.address;
                last_q   <= NB'(n_dec - (NB+1)'(1));
            end
        end
    end

    assign bus.rd_en      = (state_q == S_ISSUE);
    assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.data_addr0 = addr_q[0];
    assign bus.data_addr1 = addr_q[1];
    assign bus.data_addr2 = addr_q[2];
    assign bus.data_addr3 = addr_q[3];
    assign bus.l_data_out = ldata_q;
endmodule

// File: tb/tb_v_loadunit.sv
// Directed bench for v_loadunit: four-bank memory model with one-cycle
// read latency, hand-computed addresses, timing and packed images.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 14
`endif

module tb_v_loadunit;
    import v_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    v_loadunit_if #(.ADDR_W(14)) bus ();

    v_loadunit #(
        .VLEN   (128),
        .ADDR_W (14)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    logic [31:0] mem [0:16383];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.data_in0 <= mem[bus.data_addr0];
            bus.data_in1 <= mem[bus.data_addr1];
            bus.data_in2 <= mem[bus.data_addr2];
            bus.data_in3 <= mem[bus.data_addr3];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          rd_cnt;
    int          busy_cnt;
    int          done_cnt;
    int          done_cyc;
    logic [55:0] alog [16];

    // Issue one request, then observe 40 cycles; cycle 1 follows the
    // edge that samples start. inj_cyc>0 pulses a second start then.
    task automatic run_op(input logic [3:0] op, input logic [2:0] lm,
                          input logic [4:0] st, input logic [13:0] ad,
                          input int inj_cyc);
        rd_cnt   = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.load_op = op;
        bus.lmul    = lm;
        bus.stride  = st;
        bus.address = ad;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.rd_en) begin
                if (rd_cnt < 16)
                    alog[rd_cnt] = {bus.data_addr3, bus.data_addr2,
                                    bus.data_addr1, bus.data_addr0};
                rd_cnt++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == inj_cyc) begin
                bus.start   = 1'b1;
                bus.load_op = VLSU_VLE8;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    logic [511:0] exp_img;
    int           seen;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        nrst        = 1'b0;
        bus.start   = 1'b0;
        bus.load_op = VLSU_NOP;
        bus.lmul    = 3'b000;
        bus.stride  = 5'd0;
        bus.address = 14'h0;

        repeat (2) @(negedge clk);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", {bus.data_addr3, bus.data_addr2,
                           bus.data_addr1, bus.data_addr0}, 0);
        check("rst_ldata", bus.l_data_out, 0);
        nrst = 1'b1;

        // VLE32, one register
        mem[16] = 32'h11111111;
        mem[17] = 32'h22222222;
        mem[18] = 32'h33333333;
        mem[19] = 32'h44444444;
        run_op(VLSU_VLE32, 3'b000, 5'd0, 14'h010, 0);
        check("e32_rd_cnt", rd_cnt, 1);
        check("e32_addr", alog[0], {14'h13, 14'h12, 14'h11, 14'h10});
        check("e32_done_cyc", done_cyc, 3);
        check("e32_done_cnt", done_cnt, 1);
        check("e32_busy_cnt", busy_cnt, 2);
        check("e32_ldata", bus.l_data_out,
              128'h44444444_33333333_22222222_11111111);

        // store op in IDLE is ignored and leaves the image alone
        run_op(VLSU_VSE32, 3'b000, 5'd0, 14'h010, 0);
        check("st_rd_cnt", rd_cnt, 0);
        check("st_busy_cnt", busy_cnt, 0);
        check("st_done_cnt", done_cnt, 0);
        check("st_ldata", bus.l_data_out,
              128'h44444444_33333333_22222222_11111111);

        // VLE8, two registers
        for (int i = 0; i < 32; i++) mem[i] = 32'hFFFFFF00 | i;
        run_op(VLSU_VLE8, 3'b001, 5'd0, 14'h000, 0);
        check("e8_rd_cnt", rd_cnt, 8);
        check("e8_done_cyc", done_cyc, 10);
        check("e8_done_cnt", done_cnt, 1);
        for (int b = 0; b < 8; b++)
            check($sformatf("e8_addr_b%0d", b), alog[b],
                  {14'(4*b+3), 14'(4*b+2), 14'(4*b+1), 14'(4*b)});
        exp_img = '0;
        for (int i = 0; i < 32; i++) exp_img[8*i +: 8] = 8'(i);
        check("e8_ldata", bus.l_data_out, exp_img);

        // VLSE16 stride 3 with address wrap
        mem[14'h3FFE] = 32'hABCD0100;
        mem[14'h0001] = 32'hABCD0101;
        mem[14'h0004] = 32'hABCD0102;
        mem[14'h0007] = 32'hABCD0103;
        mem[14'h000A] = 32'hABCD0104;
        mem[14'h000D] = 32'hABCD0105;
        mem[14'h0010] = 32'hABCD0106;
        mem[14'h0013] = 32'hABCD0107;
        run_op(VLSU_VLSE16, 3'b000, 5'd3, 14'h3FFE, 0);
        check("s16_rd_cnt", rd_cnt, 2);
        check("s16_addr_b0", alog[0],
              {14'h0007, 14'h0004, 14'h0001, 14'h3FFE});
        check("s16_addr_b1", alog[1],
              {14'h0013, 14'h0010, 14'h000D, 14'h000A});
        check("s16_done_cyc", done_cyc, 4);
        check("s16_ldata", bus.l_data_out,
              128'h0107_0106_0105_0104_0103_0102_0101_0100);

        // second start during ISSUE is ignored
        mem[64] = 32'hC0000000;
        mem[65] = 32'hC1111111;
        mem[66] = 32'hC2222222;
        mem[67] = 32'hC3333333;
        run_op(VLSU_VLE32, 3'b000, 5'd0, 14'h040, 1);
        check("inj_rd_cnt", rd_cnt, 1);
        check("inj_done_cnt", done_cnt, 1);
        check("inj_done_cyc", done_cyc, 3);
        check("inj_ldata", bus.l_data_out,
              128'hC3333333_C2222222_C1111111_C0000000);

        // lmul=111 behaves as one register
        mem[32] = 32'hA0A0A0A0;
        mem[33] = 32'hA1A1A1A1;
        mem[34] = 32'hA2A2A2A2;
        mem[35] = 32'hA3A3A3A3;
        run_op(VLSU_VLE32, 3'b111, 5'd0, 14'h020, 0);
        check("l7_rd_cnt", rd_cnt, 1);
        check("l7_done_cyc", done_cyc, 3);
        check("l7_ldata", bus.l_data_out,
              128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);

        // stride 0 replicates the base word
        mem[48] = 32'hCAFEF00D;
        run_op(VLSU_VLSE32, 3'b000, 5'd0, 14'h030, 0);
        check("s0_addr", alog[0], {14'h30, 14'h30, 14'h30, 14'h30});
        check("s0_ldata", bus.l_data_out,
              128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D);

        // reset in the middle of a 16-beat load
        @(negedge clk);
        bus.start   = 1'b1;
        bus.load_op = VLSU_VLE8;
        bus.lmul    = 3'b010;
        bus.address = 14'h000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rd_en_pre", bus.rd_en, 1);
        nrst = 1'b0;
        #1;
        check("mid_rd_en", bus.rd_en, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_done", bus.done, 0);
        check("mid_ldata", bus.l_data_out, 0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done || bus.rd_en) seen++;
        end
        check("mid_no_done", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
